// File: rtl/fetch_pkg.sv
// Shared state type and constants for the instruction fetch unit.
// Build option FETCH_MISALIGN_CHECK_EN adds the FAULT state to the enum.
package fetch_pkg;

    localparam int          FETCH_ADDR_W = 32;
    localparam int          FETCH_DATA_W = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
`ifdef FETCH_MISALIGN_CHECK_EN
        HOLD,
        FAULT
`else
        HOLD
`endif
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Fetch: one outstanding imem read per pc value, result handed to decode over valid/ready.
// Latency: instr_valid in the third cycle of a fetch (REQ, WAIT, HOLD) with immediate gnt and rvalid.
// Backpressure: holds instr until instr_ready; FETCH_MISALIGN_CHECK_EN traps pc[1:0]!=0 as a fault.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W      = FETCH_ADDR_W,
    parameter int                DATA_W      = FETCH_DATA_W,
    parameter logic [DATA_W-1:0] RESET_INSTR = DATA_W'(NOP_INSTR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_en,
    input  logic              fetch_en,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic              fetch_fault
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic         drop_q;
    logic         drop_d;
    logic         valid_d;
    logic         pc_en_d;
    logic         start;
    logic         launch;
    logic         capture;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic         fault_d;
    logic         fault_set;
`endif

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        valid_d = instr_valid;
        pc_en_d = 1'b0;
        start   = 1'b0;
        launch  = 1'b0;
        capture = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_d   = fetch_fault;
        fault_set = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                start = fetch_en && !flush;
            end
            REQ: begin
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q || flush) begin
                        drop_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        capture = 1'b1;
                        valid_d = 1'b1;
                        pc_en_d = 1'b1;
                        state_d = HOLD;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                if (flush) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (instr_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                    // While pc_en is still high the pc input has not advanced yet,
                    // so relaunch from IDLE one cycle later instead of fetching a stale pc.
                    start   = fetch_en && !pc_en;
                end
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            FAULT: begin
                if (flush || instr_ready) begin
                    valid_d = 1'b0;
                    fault_d = 1'b0;
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            if (pc[1:0] != 2'b00) begin
                fault_set = 1'b1;
                fault_d   = 1'b1;
                valid_d   = 1'b1;
                state_d   = FAULT;
            end else begin
                launch  = 1'b1;
                state_d = REQ;
            end
`else
            launch  = 1'b1;
            state_d = REQ;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q      <= 1'b0;
            instr_valid <= 1'b0;
            pc_en       <= 1'b0;
            imem_addr   <= '0;
            instr       <= RESET_INSTR;
            instr_pc    <= '0;
        end else begin
            drop_q      <= drop_d;
            instr_valid <= valid_d;
            pc_en       <= pc_en_d;
            if (launch) begin
                imem_addr <= pc;
            end
            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= imem_addr;
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            if (fault_set) begin
                instr    <= RESET_INSTR;
                instr_pc <= pc;
            end
`endif
        end
    end

    // Request is a pure state decode, so it cannot glitch or be withdrawn mid-REQ.
    assign imem_req = (state_q == REQ);

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_fault <= 1'b0;
        end else begin
            fetch_fault <= fault_d;
        end
    end
`else
    assign fetch_fault = 1'b0;
`endif

endmodule
